// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the instruction
// fetch (read-only) and load/store requesters, one transaction in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifReqValid,
    output logic                ifReqReady,
    input  logic [ADDR_W-1:0]   ifReqAddr,
    output logic                ifRespValid,
    input  logic                ifRespReady,
    output logic [DATA_W-1:0]   ifRespData,
    input  logic                lsReqValid,
    output logic                lsReqReady,
    input  logic [ADDR_W-1:0]   lsReqAddr,
    input  logic                lsReqWen,
    input  logic [DATA_W-1:0]   lsReqWdata,
    input  logic [DATA_W/8-1:0] lsReqWmask,
    output logic                lsRespValid,
    input  logic                lsRespReady,
    output logic [DATA_W-1:0]   lsRespData,
    output logic                memReqValid,
    input  logic                memReqReady,
    output logic [ADDR_W-1:0]   memReqAddr,
    output logic                memReqWen,
    output logic [DATA_W-1:0]   memReqWdata,
    output logic [DATA_W/8-1:0] memReqWmask,
    input  logic                memRespValid,
    input  logic [DATA_W-1:0]   memRespData,
    output logic                busy,
    output logic                errTimeout,
    output logic                errSpurious
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W)'(MASK_W - 1));

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t              state, state_nxt;
    logic                owner_ls, last_ls;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_to_q, err_sp_q;

    logic                grant_if, grant_ls;
    logic [CNT_W-1:0]    cnt_inc;
    logic                timeout_hit;
    logic                owner_resp_ready;

    // On a conflict the requester that was not served last time wins.
    assign grant_ls = lsReqValid && (!ifReqValid || !last_ls);
    assign grant_if = ifReqValid && !grant_ls;

    assign cnt_inc          = cnt_q + CNT_W'(1);
    assign timeout_hit      = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
    assign owner_resp_ready = owner_ls ? lsRespReady : ifRespReady;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (grant_if || grant_ls)            state_nxt = S_REQ;
            S_REQ:  if (memReqReady)                     state_nxt = S_WAIT;
            S_WAIT: if (memRespValid || timeout_hit)     state_nxt = S_RESP;
            S_RESP: if (owner_resp_ready)                state_nxt = S_IDLE;
            default:                                     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            owner_ls <= 1'b0;
            last_ls  <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            err_to_q <= 1'b0;
            err_sp_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (grant_ls) begin
                        owner_ls <= 1'b1;
                        addr_q   <= lsReqAddr;
                        wen_q    <= lsReqWen;
                        wdata_q  <= lsReqWdata;
                        wmask_q  <= lsReqWmask;
                    end else if (grant_if) begin
                        owner_ls <= 1'b0;
                        addr_q   <= ifReqAddr;
                        wen_q    <= 1'b0;
                        wdata_q  <= '0;
                        wmask_q  <= '0;
                    end
                end
                S_REQ: if (memReqReady) cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_inc;
                    // A real response in the timeout cycle beats the forced one.
                    if (memRespValid) begin
                        rdata_q <= memRespData;
                    end else if (timeout_hit) begin
                        rdata_q  <= '1;
                        err_to_q <= 1'b1;
                    end
                end
                S_RESP: if (owner_resp_ready) last_ls <= owner_ls;
                default: ;
            endcase
            if (memRespValid && state != S_WAIT) err_sp_q <= 1'b1;
        end
    end

    assign ifReqReady  = (state == S_IDLE) && grant_if;
    assign lsReqReady  = (state == S_IDLE) && grant_ls;

    assign memReqValid = (state == S_REQ);
    assign memReqAddr  = addr_q & ALIGN_MASK;
    assign memReqWen   = wen_q;
    assign memReqWdata = wdata_q;
    assign memReqWmask = wmask_q;

    assign ifRespValid = (state == S_RESP) && !owner_ls;
    assign lsRespValid = (state == S_RESP) && owner_ls;
    assign ifRespData  = rdata_q;
    assign lsRespData  = rdata_q;

    assign busy        = (state != S_IDLE);
    assign errTimeout  = err_to_q;
    assign errSpurious = err_sp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level bench for mem_arbiter: directed scenarios plus randomized
// request/latency/backpressure mixes checked against a round-robin reference model.
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          ifReqValid, ifReqReady, ifRespValid, ifRespReady;
    logic [AW-1:0] ifReqAddr;
    logic [DW-1:0] ifRespData;
    logic          lsReqValid, lsReqReady, lsReqWen, lsRespValid, lsRespReady;
    logic [AW-1:0] lsReqAddr;
    logic [DW-1:0] lsReqWdata, lsRespData;
    logic [MW-1:0] lsReqWmask;
    logic          memReqValid, memReqReady, memReqWen, memRespValid;
    logic [AW-1:0] memReqAddr;
    logic [DW-1:0] memReqWdata, memRespData;
    logic [MW-1:0] memReqWmask;
    logic          busy, errTimeout, errSpurious;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .ifReqValid(ifReqValid), .ifReqReady(ifReqReady), .ifReqAddr(ifReqAddr),
        .ifRespValid(ifRespValid), .ifRespReady(ifRespReady), .ifRespData(ifRespData),
        .lsReqValid(lsReqValid), .lsReqReady(lsReqReady), .lsReqAddr(lsReqAddr),
        .lsReqWen(lsReqWen), .lsReqWdata(lsReqWdata), .lsReqWmask(lsReqWmask),
        .lsRespValid(lsRespValid), .lsRespReady(lsRespReady), .lsRespData(lsRespData),
        .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
        .memReqWen(memReqWen), .memReqWdata(memReqWdata), .memReqWmask(memReqWmask),
        .memRespValid(memRespValid), .memRespData(memRespData),
        .busy(busy), .errTimeout(errTimeout), .errSpurious(errSpurious)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: pending requests, their fields, last grant, sticky flags.
    logic          if_pend, ls_pend, last_ls;
    logic [AW-1:0] if_addr, ls_addr;
    logic          ls_wen;
    logic [DW-1:0] ls_wdata;
    logic [MW-1:0] ls_wmask;
    logic          exp_terr, exp_spur;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_if(input logic [AW-1:0] a);
        if_addr = a; if_pend = 1'b1;
        ifReqAddr = a; ifReqValid = 1'b1;
    endtask

    task automatic set_ls(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
        ls_addr = a; ls_wen = w; ls_wdata = d; ls_wmask = m; ls_pend = 1'b1;
        lsReqAddr = a; lsReqWen = w; lsReqWdata = d; lsReqWmask = m; lsReqValid = 1'b1;
    endtask

    // One full transaction from IDLE: d cycles of memReqReady=0, response in WAIT
    // cycle k (k=0 means no response, expect timeout), r cycles of response backpressure.
    task automatic run_txn(input int d, input int k, input logic [DW-1:0] rdata, input int r);
        logic          exp_ls, exp_wen;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [MW-1:0] exp_mask;
        exp_ls   = ls_pend && (!if_pend || !last_ls);
        exp_addr = (exp_ls ? ls_addr : if_addr) & ~64'h7;
        exp_wen  = exp_ls && ls_wen;
        exp_mask = exp_ls ? ls_wmask : '0;
        exp_data = (k == 0) ? '1 : rdata;
        #1;
        chk1("ifReqReady_grant", ifReqReady, !exp_ls);
        chk1("lsReqReady_grant", lsReqReady, exp_ls);
        tick();
        if (exp_ls) begin lsReqValid = 1'b0; ls_pend = 1'b0; end
        else        begin ifReqValid = 1'b0; if_pend = 1'b0; end
        for (int i = 0; i <= d; i++) begin
            memReqReady = (i == d);
            #1;
            chk1("memReqValid_req", memReqValid, 1'b1);
            chk64("memReqAddr", memReqAddr, exp_addr);
            chk1("memReqWen", memReqWen, exp_wen);
            chk64("memReqWmask", 64'(memReqWmask), 64'(exp_mask));
            if (exp_ls) chk64("memReqWdata", memReqWdata, ls_wdata);
            chk1("ifReqReady_req", ifReqReady, 1'b0);
            chk1("lsReqReady_req", lsReqReady, 1'b0);
            tick();
        end
        memReqReady = 1'b0;
        #1;
        chk1("memReqValid_wait", memReqValid, 1'b0);
        chk1("busy_wait", busy, 1'b1);
        if (k == 0) begin
            repeat (TO - 1) tick();
            chk1("no_early_resp", ifRespValid | lsRespValid, 1'b0);
            tick();
            exp_terr = 1'b1;
        end else begin
            repeat (k - 1) tick();
            memRespValid = 1'b1;
            memRespData  = rdata;
            tick();
            memRespValid = 1'b0;
        end
        for (int i = 0; i <= r; i++) begin
            if (i == r) begin
                if (exp_ls) lsRespReady = 1'b1; else ifRespReady = 1'b1;
            end
            #1;
            chk1("ifRespValid", ifRespValid, !exp_ls);
            chk1("lsRespValid", lsRespValid, exp_ls);
            chk64("respData", exp_ls ? lsRespData : ifRespData, exp_data);
            chk1("ifReqReady_resp", ifReqReady, 1'b0);
            chk1("lsReqReady_resp", lsReqReady, 1'b0);
            chk1("errTimeout", errTimeout, exp_terr);
            tick();
        end
        ifRespReady = 1'b0;
        lsRespReady = 1'b0;
        last_ls = exp_ls;
        #1;
        chk1("busy_idle", busy, 1'b0);
        chk1("resp_cleared", ifRespValid | lsRespValid, 1'b0);
        chk1("errSpurious", errSpurious, exp_spur);
    endtask

    initial begin
        reset = 1'b0;
        ifReqValid = 1'b0; ifReqAddr = '0; ifRespReady = 1'b0;
        lsReqValid = 1'b0; lsReqAddr = '0; lsReqWen = 1'b0; lsReqWdata = '0; lsReqWmask = '0;
        lsRespReady = 1'b0; memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0;
        if_pend = 1'b0; ls_pend = 1'b0; last_ls = 1'b0; exp_terr = 1'b0; exp_spur = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;

        #12;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_memReqValid", memReqValid, 1'b0);
        chk64("rst_memReqAddr", memReqAddr, 64'h0);
        chk1("rst_memReqWen", memReqWen, 1'b0);
        chk64("rst_memReqWmask", 64'(memReqWmask), 64'h0);
        chk1("rst_respValid", ifRespValid | lsRespValid, 1'b0);
        chk1("rst_reqReady", ifReqReady | lsReqReady, 1'b0);
        chk1("rst_errTimeout", errTimeout, 1'b0);
        chk1("rst_errSpurious", errSpurious, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk1("idle_noreq_ready", ifReqReady | lsReqReady, 1'b0);

        // Both requesters held: expect LSU, IF, LSU, IF.
        set_if(64'h1000);
        set_ls(64'h2000, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            chk1("rr_order", ls_pend && (!if_pend || !last_ls), (i % 2) == 0);
            run_txn(0, 1, {$urandom, $urandom}, 0);
            if (i < 2) begin
                if (last_ls) set_ls(64'h2000 + 64'(i * 8), 1'b0, '0, '0);
                else         set_if(64'h1000 + 64'(i * 8));
            end
        end

        // IF-only read with unaligned address.
        set_if(64'h80000004);
        run_txn(0, 2, 64'h1122334455667788, 0);

        // LSU write held through three cycles of memory backpressure.
        set_ls(64'h80000010, 1'b1, 64'hDEADBEEF, 8'h0F);
        run_txn(3, 1, {$urandom, $urandom}, 0);

        // IF response backpressure while an LSU request waits, then LSU served.
        set_if(64'h3000);
        set_ls(64'h4008, 1'b0, '0, '0);
        run_txn(0, 1, {$urandom, $urandom}, 5);
        run_txn(0, 1, {$urandom, $urandom}, 0);

        // Response in the last WAIT cycle beats the timeout.
        set_if(64'h5000);
        run_txn(1, TO, 64'h0123456789ABCDEF, 1);

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) set_if({$urandom, $urandom});
            if (!ls_pend && $urandom_range(0, 1) == 1)
                set_ls({$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                       8'($urandom));
            if (!if_pend && !ls_pend) set_if({$urandom, $urandom});
            run_txn($urandom_range(0, 3), $urandom_range(1, TO), {$urandom, $urandom},
                    $urandom_range(0, 3));
        end
        for (int n = 0; n < 2; n++)
            if (if_pend || ls_pend) run_txn(0, 1, {$urandom, $urandom}, 0);

        // Timeout: no memory response at all.
        set_ls(64'h6000, 1'b0, '0, '0);
        run_txn(0, 0, '0, 0);

        // Late response arriving in IDLE is spurious.
        memRespValid = 1'b1;
        memRespData  = 64'hBADBADBADBADBAD0;
        tick();
        memRespValid = 1'b0;
        exp_spur = 1'b1;
        #1;
        chk1("spurious_set", errSpurious, 1'b1);
        chk1("spurious_busy", busy, 1'b0);

        // Reset mid-transaction: once in REQ, once in WAIT.
        for (int s = 0; s < 2; s++) begin
            set_if(64'h7000);
            #1;
            tick();
            ifReqValid = 1'b0; if_pend = 1'b0;
            if (s == 1) begin
                memReqReady = 1'b1;
                tick();
                memReqReady = 1'b0;
            end
            #1;
            chk1("pre_rst_memReqValid", memReqValid, s == 0);
            chk1("pre_rst_busy", busy, 1'b1);
            reset = 1'b0;
            #1;
            chk1("async_rst_busy", busy, 1'b0);
            chk1("async_rst_memReqValid", memReqValid, 1'b0);
            chk1("async_rst_resp", ifRespValid | lsRespValid, 1'b0);
            chk1("async_rst_errs", errTimeout | errSpurious, 1'b0);
            last_ls = 1'b0; exp_terr = 1'b0; exp_spur = 1'b0;
            #2;
            reset = 1'b1;
            tick();
            set_if(64'h80000008);
            run_txn(0, 1, {$urandom, $urandom}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
